// File: rtl/armleocpu_ptw.sv
// armleocpu_ptw: Sv32 two-level page-table walker over an Avalon-MM read master
module armleocpu_ptw (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        resolve_request,
  input  logic [19:0] virtual_address,
  output logic        resolve_ack,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [7:0]  resolve_access_bits,
  output logic [21:0] resolve_physical_address,
  input  logic        matp_mode,
  input  logic [21:0] matp_ppn,
  output logic [33:0] avl_address,
  output logic        avl_read,
  input  logic        avl_waitrequest,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  input  logic [1:0]  avl_response,
  output logic [24:0] state_debug_output
);
  typedef enum logic [3:0] {IDLE = 4'd0, ISSUE = 4'd1, WAIT = 4'd2, DONE = 4'd3} state_t;
  state_t state;
  logic level;
  logic [19:0] vpn;
  logic [21:0] pte_ppn;
  logic err, bad, leaf, misaligned, fault, descend, success;
  logic unused_rsw;
  assign unused_rsw = ^avl_readdata[9:8];
  always_comb begin
    avl_read = (state == IDLE && resolve_request && matp_mode) || state == ISSUE;
    avl_address = state == ISSUE ? {pte_ppn, vpn[9:0], 2'b00} : {matp_ppn, virtual_address[19:10], 2'b00};
    resolve_ack = state == IDLE && resolve_request && (!matp_mode || !avl_waitrequest);
    err = |avl_response;
    leaf = avl_readdata[1] | avl_readdata[3];
    bad = !avl_readdata[0] || (avl_readdata[2] && !avl_readdata[1]);
    misaligned = leaf && level && |avl_readdata[19:10];
    fault = !err && (bad || misaligned || (!leaf && !level));
    descend = !err && !bad && !leaf && level;
    success = !err && !fault && leaf;
    state_debug_output = {state, level, vpn};
  end
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state <= IDLE;
      level <= 1'b1;
      vpn <= '0;
      pte_ppn <= '0;
      resolve_done <= 1'b0;
      resolve_pagefault <= 1'b0;
      resolve_accessfault <= 1'b0;
      resolve_access_bits <= '0;
      resolve_physical_address <= '0;
    end else begin
      resolve_done <= 1'b0;
      case (state)
        IDLE: if (resolve_ack) begin
          vpn <= virtual_address;
          level <= 1'b1;
          state <= matp_mode ? WAIT : DONE;
          if (!matp_mode) begin
            resolve_done <= 1'b1;
            resolve_pagefault <= 1'b0;
            resolve_accessfault <= 1'b0;
            resolve_access_bits <= 8'hCF;
            resolve_physical_address <= {2'b00, virtual_address};
          end
        end
        ISSUE: if (!avl_waitrequest) begin
          level <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (avl_readdatavalid) begin
          if (descend) begin
            pte_ppn <= avl_readdata[31:10];
            state <= ISSUE;
          end else begin
            state <= DONE;
            resolve_done <= 1'b1;
            resolve_pagefault <= fault;
            resolve_accessfault <= err;
            resolve_access_bits <= success ? avl_readdata[7:0] : 8'h00;
            resolve_physical_address <= !success ? 22'h0 :
              level ? {avl_readdata[31:20], vpn[9:0]} : avl_readdata[31:10];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_armleocpu_ptw.sv
// tb_armleocpu_ptw: directed checks of the Sv32 walker against a small Avalon memory model
module tb_armleocpu_ptw;
  logic clk = 1'b0;
  logic async_rst = 1'b1;
  logic resolve_request = 1'b0;
  logic [19:0] virtual_address = '0;
  logic resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [7:0] resolve_access_bits;
  logic [21:0] resolve_physical_address;
  logic matp_mode = 1'b1;
  logic [21:0] matp_ppn = '0;
  logic [33:0] avl_address;
  logic avl_read, avl_waitrequest;
  logic avl_readdatavalid = 1'b0;
  logic [31:0] avl_readdata = '0;
  logic [1:0] avl_response = '0;
  logic [24:0] state_debug_output;
  logic [31:0] mem [4096];
  logic [1:0] err_mem [4096];
  logic [33:0] rd_log [$];
  int stall = 0;
  int stalled = 0;
  int n_checks = 0;
  int n_fail = 0;
  int ack_c;
  armleocpu_ptw dut (
    .clk(clk), .async_rst(async_rst), .resolve_request(resolve_request),
    .virtual_address(virtual_address), .resolve_ack(resolve_ack), .resolve_done(resolve_done),
    .resolve_pagefault(resolve_pagefault), .resolve_accessfault(resolve_accessfault),
    .resolve_access_bits(resolve_access_bits), .resolve_physical_address(resolve_physical_address),
    .matp_mode(matp_mode), .matp_ppn(matp_ppn), .avl_address(avl_address), .avl_read(avl_read),
    .avl_waitrequest(avl_waitrequest), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .avl_response(avl_response),
    .state_debug_output(state_debug_output)
  );
  always #5 clk = ~clk;
  assign avl_waitrequest = avl_read && (stalled < stall);
  always @(posedge clk) begin
    avl_readdatavalid <= avl_read && !avl_waitrequest;
    avl_readdata <= mem[avl_address[13:2]];
    avl_response <= err_mem[avl_address[13:2]];
    if (avl_read) rd_log.push_back(avl_address);
    if (resolve_done) stalled <= 0;
    else if (avl_read && avl_waitrequest) stalled <= stalled + 1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic walk(input string tag, input logic [19:0] va, input int lat, input logic pf,
                      input logic af, input logic [7:0] bits, input logic [21:0] phys);
    int c;
    rd_log.delete();
    @(negedge clk);
    resolve_request = 1'b1;
    virtual_address = va;
    c = 0;
    ack_c = -1;
    while (!resolve_done && c < 40) begin
      #1 if (resolve_ack && ack_c < 0) ack_c = c;
      @(negedge clk);
      c++;
      if (ack_c >= 0) resolve_request = 1'b0;
    end
    resolve_request = 1'b0;
    check({tag, "_lat"}, c, lat);
    check({tag, "_pf"}, resolve_pagefault, pf);
    check({tag, "_af"}, resolve_accessfault, af);
    check({tag, "_bits"}, resolve_access_bits, bits);
    check({tag, "_phys"}, resolve_physical_address, phys);
  endtask
  initial begin
    logic seen;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h0;
      err_mem[i] = 2'b00;
    end
    err_mem[1] = 2'b11;
    mem[2] = 32'h00000401;
    err_mem[1024] = 2'b10;
    mem[3] = 32'h001000CF;
    mem[4] = 32'h00100007;
    mem[5] = 32'h0010000B;
    mem[6] = 32'h00100003;
    mem[7] = 32'h00100009;
    mem[13] = 32'h0010040F;
    mem[20] = 32'h00000801;
    mem[2051] = 32'h048D14C7;
    mem[2052] = 32'h00000000;
    mem[2053] = 32'h00000005;
    mem[2054] = 32'h0000000D;
    mem[2055] = 32'h00000801;
    mem[21] = 32'h00100000;
    mem[22] = 32'h00100005;
    mem[23] = 32'h0010000D;
    repeat (2) @(negedge clk);
    async_rst = 1'b0;
    @(negedge clk);
    check("rst_done", resolve_done, 1'b0);
    check("rst_debug", state_debug_output, 25'h0100000);
    check("rst_phys", resolve_physical_address, 22'h0);
    check("rst_bits", resolve_access_bits, 8'h0);
    check("rst_read", avl_read, 1'b0);
    walk("l1_err", {10'd1, 10'd0}, 2, 1'b0, 1'b1, 8'h00, 22'h0);
    check("l1_err_addr", rd_log[0], 34'h4);
    walk("l0_err", {10'd2, 10'd0}, 4, 1'b0, 1'b1, 8'h00, 22'h0);
    check("l0_err_nreads", rd_log.size(), 2);
    check("l0_err_addr0", rd_log[0], 34'h8);
    check("l0_err_addr1", rd_log[1], 34'h1000);
    walk("mp_rwx", {10'd3, 10'h2A}, 2, 1'b0, 1'b0, 8'hCF, 22'h00042A);
    walk("mp_rw", {10'd4, 10'd0}, 2, 1'b0, 1'b0, 8'h07, 22'h000400);
    walk("mp_rx", {10'd5, 10'd0}, 2, 1'b0, 1'b0, 8'h0B, 22'h000400);
    walk("mp_r", {10'd6, 10'd0}, 2, 1'b0, 1'b0, 8'h03, 22'h000400);
    walk("mp_x", {10'd7, 10'd0}, 2, 1'b0, 1'b0, 8'h09, 22'h000400);
    repeat (2) @(negedge clk);
    check("hold_phys", resolve_physical_address, 22'h000400);
    check("hold_done", resolve_done, 1'b0);
    walk("misalign", {10'd13, 10'd0}, 2, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l0_leaf", {10'd20, 10'd3}, 4, 1'b0, 1'b0, 8'hC7, 22'h12345);
    check("l0_leaf_addr1", rd_log[1], 34'h200C);
    walk("l0_inval", {10'd20, 10'd4}, 4, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l0_wonly", {10'd20, 10'd5}, 4, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l0_wx", {10'd20, 10'd6}, 4, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l0_ptr", {10'd20, 10'd7}, 4, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l1_inval", {10'd21, 10'd0}, 2, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l1_wonly", {10'd22, 10'd0}, 2, 1'b1, 1'b0, 8'h00, 22'h0);
    walk("l1_wx", {10'd23, 10'd0}, 2, 1'b1, 1'b0, 8'h00, 22'h0);
    matp_mode = 1'b0;
    walk("bare", 20'hABCDE, 1, 1'b0, 1'b0, 8'hCF, 22'h0ABCDE);
    check("bare_nreads", rd_log.size(), 0);
    matp_mode = 1'b1;
    stall = 3;
    walk("stall", {10'd4, 10'd0}, 5, 1'b0, 1'b0, 8'h07, 22'h000400);
    stall = 0;
    check("stall_ack", ack_c, 3);
    check("stall_nreads", rd_log.size(), 4);
    foreach (rd_log[i]) check("stall_addr", rd_log[i], 34'h10);
    @(negedge clk);
    resolve_request = 1'b1;
    virtual_address = {10'd20, 10'd3};
    @(negedge clk);
    #1 async_rst = 1'b1;
    #1 check("midrst_debug", state_debug_output, 25'h0100000);
    resolve_request = 1'b0;
    #1 async_rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | resolve_done;
    end
    check("midrst_nodone", seen, 1'b0);
    walk("after_rst", {10'd20, 10'd3}, 4, 1'b0, 1'b0, 8'hC7, 22'h12345);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
